// File: rtl/bomberman_pkg.sv
// bomberman_pkg: shared constants and types for the game datapath.
//   SCREEN_W/SCREEN_H : frame buffer geometry (160x120)
//   TILE_W            : sprite tile edge length (16x16 tiles)
//   MEM_*             : memory_select encodings for the image ROMs
//   copy_state_e      : frame_copy_engine FSM states
package bomberman_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned TILE_W   = 16;

    localparam logic [1:0] MEM_TITLE  = 2'd0;
    localparam logic [1:0] MEM_STAGE  = 2'd1;
    localparam logic [1:0] MEM_WIN    = 2'd2;
    localparam logic [1:0] MEM_SPRITE = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } copy_state_e;

endpackage

// File: rtl/pixel_scan_counter.sv
// pixel_scan_counter: two-level column/row scan counter, row-major order.
// Ports:
//   i_clock, i_resetn : clock, async active-low reset
//   i_clear           : synchronous clear to (0,0), wins over i_advance
//   i_advance         : step to the next pixel
//   i_col_max/i_row_max : last column/row index (runtime limits)
//   o_col, o_row      : current pixel coordinates
//   o_last            : current pixel is the final one of the scan
module pixel_scan_counter (
    input  logic       i_clock,
    input  logic       i_resetn,
    input  logic       i_clear,
    input  logic       i_advance,
    input  logic [7:0] i_col_max,
    input  logic [6:0] i_row_max,
    output logic [7:0] o_col,
    output logic [6:0] o_row,
    output logic       o_last
);

    logic [7:0] r_col;
    logic [6:0] r_row;
    logic       w_col_end;
    logic       w_row_end;

    assign w_col_end = (r_col == i_col_max);
    assign w_row_end = (r_row == i_row_max);

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_advance) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? 7'd0 : r_row + 7'd1;
            end else begin
                r_col <= r_col + 8'd1;
            end
        end
    end

    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_last = w_col_end && w_row_end;

endmodule

// File: rtl/frame_copy_engine.sv
// frame_copy_engine: copies a 160x120 background or a 16x16 sprite tile from the
// selected image ROM into the frame buffer, then pulses finished.
// Ports:
//   clock, resetn        : clock, async active-low reset
//   copy_enable          : command request, sampled only when idle
//   memory_select        : source ROM (title/stage/win/sprite sheet)
//   full_screen          : 1 = full background copy, 0 = one tile
//   dest_x, dest_y       : tile origin in the frame buffer
//   sprite_index         : tile number within the sprite sheet
//   rom_sel, rom_addr    : ROM mux select and read address
//   rom_data             : ROM read data, one cycle after rom_addr
//   fb_addr, fb_data, fb_we : frame buffer write port
//   busy, finished       : engine active / single-cycle completion pulse
// Build option: define TRANSPARENCY_EN to skip tile pixels equal to TRANSPARENT_COLOR.
module frame_copy_engine
    import bomberman_pkg::*;
#(
    parameter int unsigned         COLOR_W           = 3,
    parameter logic [COLOR_W-1:0]  TRANSPARENT_COLOR = '0
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               copy_enable,
    input  logic [1:0]         memory_select,
    input  logic               full_screen,
    input  logic [7:0]         dest_x,
    input  logic [6:0]         dest_y,
    input  logic [3:0]         sprite_index,
    output logic [1:0]         rom_sel,
    output logic [14:0]        rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [14:0]        fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic               fb_we,
    output logic               busy,
    output logic               finished
);

    copy_state_e r_state;
    copy_state_e w_state_next;

    logic [1:0]  r_sel;
    logic        r_full;
    logic [7:0]  r_dx;
    logic [6:0]  r_dy;
    logic [3:0]  r_idx;

    logic [7:0]  w_col;
    logic [6:0]  w_row;
    logic        w_last;
    logic        w_clear;
    logic        w_advance;
    logic [7:0]  w_col_max;
    logic [6:0]  w_row_max;

    logic [8:0]  w_x;
    logic [7:0]  w_y;
    logic        w_in_bounds;
    logic [14:0] w_dst;
    logic [14:0] r_fb_addr;
    logic        r_we;
    logic        w_drop;

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        finished     = 1'b0;
        w_clear      = 1'b0;
        w_advance    = 1'b0;
        unique case (r_state)
            StIdle: begin
                busy    = 1'b0;
                w_clear = 1'b1;
                if (copy_enable) w_state_next = StRun;
            end
            StRun: begin
                w_advance = 1'b1;
                if (w_last) w_state_next = StFlush;
            end
            StFlush: w_state_next = StDone;
            StDone: begin
                finished     = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Command parameters are captured on the IDLE->RUN edge only.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sel  <= '0;
            r_full <= 1'b0;
            r_dx   <= '0;
            r_dy   <= '0;
            r_idx  <= '0;
        end else if ((r_state == StIdle) && copy_enable) begin
            r_sel  <= memory_select;
            r_full <= full_screen;
            r_dx   <= dest_x;
            r_dy   <= dest_y;
            r_idx  <= sprite_index;
        end
    end

    // ---------------- Scan ----------------
    assign w_col_max = r_full ? 8'(SCREEN_W - 1) : 8'(TILE_W - 1);
    assign w_row_max = r_full ? 7'(SCREEN_H - 1) : 7'(TILE_W - 1);

    pixel_scan_counter u_scan (
        .i_clock   (clock),
        .i_resetn  (resetn),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .i_col_max (w_col_max),
        .i_row_max (w_row_max),
        .o_col     (w_col),
        .o_row     (w_row),
        .o_last    (w_last)
    );

    // Tile rows/cols stay below 16, so the tile address is a plain concatenation.
    assign rom_addr = r_full ? (15'({w_row, 7'd0}) + 15'({w_row, 5'd0}) + 15'(w_col))
                             : {r_idx, w_row[3:0], w_col[3:0]};

    // Widened sums so an off-screen tile pixel cannot wrap back on screen.
    assign w_x = {1'b0, (r_full ? 8'd0 : r_dx)} + {1'b0, w_col};
    assign w_y = {1'b0, (r_full ? 7'd0 : r_dy)} + {1'b0, w_row};
    assign w_in_bounds = (w_x < 9'(SCREEN_W)) && (w_y < 8'(SCREEN_H));
    assign w_dst = 15'({w_y, 7'd0}) + 15'({w_y, 5'd0}) + 15'(w_x);

    // ---------------- Write stage (aligned with rom_data) ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_we      <= 1'b0;
            r_fb_addr <= '0;
        end else begin
            r_we      <= (r_state == StRun) && w_in_bounds;
            r_fb_addr <= (r_state == StRun) ? w_dst : 15'd0;
        end
    end

`ifdef TRANSPARENCY_EN
    assign w_drop = !r_full && (rom_data == TRANSPARENT_COLOR);
`else
    logic w_unused_key;
    assign w_unused_key = (rom_data == TRANSPARENT_COLOR);
    assign w_drop       = 1'b0;
`endif

    assign rom_sel = r_sel;
    assign fb_addr = r_fb_addr;
    assign fb_we   = r_we && !w_drop;
    assign fb_data = r_we ? rom_data : '0;

endmodule

// File: tb/tb_frame_copy_engine.sv
// tb_frame_copy_engine: directed self-checking bench for frame_copy_engine.
module tb_frame_copy_engine;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        copy_enable = 1'b0;
    logic [1:0]  memory_select = '0;
    logic        full_screen = 1'b0;
    logic [7:0]  dest_x = '0;
    logic [6:0]  dest_y = '0;
    logic [3:0]  sprite_index = '0;
    logic [1:0]  rom_sel;
    logic [14:0] rom_addr;
    logic [2:0]  rom_data = '0;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        busy;
    logic        finished;

    always #5 clock = ~clock;

    frame_copy_engine #(
        .COLOR_W           (3),
        .TRANSPARENT_COLOR (3'd0)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .copy_enable   (copy_enable),
        .memory_select (memory_select),
        .full_screen   (full_screen),
        .dest_x        (dest_x),
        .dest_y        (dest_y),
        .sprite_index  (sprite_index),
        .rom_sel       (rom_sel),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .fb_addr       (fb_addr),
        .fb_data       (fb_data),
        .fb_we         (fb_we),
        .busy          (busy),
        .finished      (finished)
    );

    // ROM model: one-cycle read latency; mode 1 gives 0 on even addresses.
    logic rom_mode = 1'b0;
    always @(posedge clock) begin
        rom_data <= rom_mode ? (rom_addr[0] ? 3'd5 : 3'd0) : rom_addr[2:0];
    end

    int tick = 0;
    always @(posedge clock) tick <= tick + 1;

    int n_chk = 0;
    int n_pass = 0;
    int t0 = 0;
    int wr_cnt, fin_cnt, oob, dbl_fin;
    int first_fb, last_fb, last_data, d_19199;
    int first_wr_cyc, last_wr_cyc, fin_t0, fin_t1;
    int first_rom, sel_seen;
    logic prev_fin = 1'b0;
    logic clip_chk = 1'b0;

    always @(negedge clock) begin
        int a;
        if (fb_we) begin
            a = int'(fb_addr);
            if (wr_cnt == 0) begin
                first_fb     = a;
                first_wr_cyc = tick - t0;
            end
            wr_cnt++;
            last_fb     = a;
            last_data   = int'(fb_data);
            last_wr_cyc = tick - t0;
            if (a == 19199) d_19199 = int'(fb_data);
            if (a >= 19200) oob++;
            if (clip_chk && ((a % 160) < 152 || (a / 160) < 112)) oob++;
        end
        if (finished) begin
            if (fin_cnt == 0) fin_t0 = tick - t0;
            else fin_t1 = tick - t0;
            fin_cnt++;
            if (prev_fin) dbl_fin++;
        end
        prev_fin = finished;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_stats();
        wr_cnt = 0; fin_cnt = 0; oob = 0; dbl_fin = 0;
        first_fb = -1; last_fb = -1; last_data = -1; d_19199 = -1;
        first_wr_cyc = -1; last_wr_cyc = -1; fin_t0 = -1; fin_t1 = -1;
    endtask

    // Issues a command; t0 marks cycle 0 (first RUN cycle).
    task automatic start_cmd(input logic full, input logic [1:0] sel, input logic [7:0] dx,
                             input logic [6:0] dy, input logic [3:0] idx, input logic hold);
        @(negedge clock);
        full_screen   = full;
        memory_select = sel;
        dest_x        = dx;
        dest_y        = dy;
        sprite_index  = idx;
        copy_enable   = 1'b1;
        @(posedge clock);
        #1;
        t0 = tick;
        clear_stats();
        first_rom = int'(rom_addr);
        sel_seen  = int'(rom_sel);
        if (!hold) copy_enable = 1'b0;
    endtask

    task automatic wait_fin(input int n, input int budget);
        int k = 0;
        while (fin_cnt < n && k < budget) begin
            @(negedge clock);
            #1;
            k++;
        end
        check("finish_timeout", int'(fin_cnt >= n), 1);
    endtask

    initial begin
        int k;
        clear_stats();
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_addr", int'({rom_addr, fb_addr}), 0);
        check("rst_ctl", int'({rom_sel, fb_data, fb_we, busy, finished}), 0);
        resetn = 1'b1;
        @(negedge clock);
        check("idle_busy", int'({busy, finished, fb_we}), 0);

        // Full-screen copy from the stage ROM; dest/index must be ignored
        start_cmd(1'b1, 2'd1, 8'd5, 7'd5, 4'd7, 1'b0);
        check("full_sel", sel_seen, 1);
        check("full_rom0", first_rom, 0);
        wait_fin(1, 20000);
        repeat (3) @(negedge clock);
        check("full_writes", wr_cnt, 19200);
        check("full_d19199", d_19199, 7);
        check("full_fin_cyc", fin_t0, 19201);
        check("full_fin_cnt", fin_cnt, 1);
        check("full_first_fb", first_fb, 0);
        check("full_wr_cycles", first_wr_cyc * 100000 + last_wr_cyc, 100000 + 19200);
        check("full_dbl_fin", dbl_fin, 0);

        // Tile 2 at (32,48)
        start_cmd(1'b0, 2'd3, 8'd32, 7'd48, 4'd2, 1'b0);
        check("tile_rom0", first_rom, 512);
        wait_fin(1, 400);
        check("tile_first_fb", first_fb, 7712);
        check("tile_last_fb", last_fb, 10127);
        check("tile_writes", wr_cnt, 256);
        check("tile_last_data", last_data, 7);
        check("tile_fin_cyc", fin_t0, 257);

        // Tile clipped at the bottom-right corner
        clip_chk = 1'b1;
        start_cmd(1'b0, 2'd3, 8'd152, 7'd112, 4'd0, 1'b0);
        wait_fin(1, 400);
        clip_chk = 1'b0;
        check("clip_writes", wr_cnt, 64);
        check("clip_oob", oob, 0);
        check("clip_first_fb", first_fb, 18072);
        check("clip_last_fb", last_fb, 19199);
        check("clip_fin_cyc", fin_t0, 257);

        // copy_enable held across two commands; second uses new inputs
        start_cmd(1'b0, 2'd3, 8'd0, 7'd0, 4'd1, 1'b1);
        check("held_rom0_a", first_rom, 256);
        wait_fin(1, 400);
        sprite_index = 4'd3;
        dest_x       = 8'd16;
        dest_y       = 7'd16;
        @(posedge clock);
        @(posedge clock);
        #1;
        copy_enable = 1'b0;
        check("held_rom0_b", int'(rom_addr), 768);
        wait_fin(2, 400);
        check("held_fin0", fin_t0, 257);
        check("held_gap", fin_t1 - fin_t0, 259);
        check("held_last_fb", last_fb, 4991);
        check("held_dbl_fin", dbl_fin, 0);

        // Reset mid-command
        start_cmd(1'b0, 2'd3, 8'd40, 7'd20, 4'd5, 1'b0);
        k = 0;
        while ((tick - t0) < 100 && k < 500) begin
            @(negedge clock);
            k++;
        end
        check("mid_busy", int'({busy, rom_sel}), 7);
        #1;
        resetn = 1'b0;
        #1;
        check("mid_rst_addr", int'({rom_addr, fb_addr}), 0);
        check("mid_rst_ctl", int'({rom_sel, fb_data, fb_we, busy, finished}), 0);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (300) @(negedge clock);
        check("mid_no_fin", fin_cnt, 0);
        start_cmd(1'b0, 2'd3, 8'd32, 7'd48, 4'd2, 1'b0);
        wait_fin(1, 400);
        check("post_rst_writes", wr_cnt, 256);
        check("post_rst_first_fb", first_fb, 7712);
        check("post_rst_fin_cyc", fin_t0, 257);

        // Key-colour tile: zero on even columns
        rom_mode = 1'b1;
        start_cmd(1'b0, 2'd3, 8'd0, 7'd0, 4'd0, 1'b0);
        wait_fin(1, 400);
        rom_mode = 1'b0;
`ifdef TRANSPARENCY_EN
        check("key_writes", wr_cnt, 128);
`else
        check("key_writes", wr_cnt, 256);
`endif
        check("key_fin_cyc", fin_t0, 257);

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
